// File: rtl/vga_fb_pkg.sv
// ---------------------------------------------------------------------------
// vga_fb_pkg : shared defaults and enums for the framebuffer arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_fb_pkg;

    localparam int DEF_ADDR_W    = 19;
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_FRAME_PIX = 307200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_HOST = 2'd2
    } fb_gnt_e;

endpackage

`default_nettype wire

// File: rtl/fb_pixel_fifo.sv
// ---------------------------------------------------------------------------
// fb_pixel_fifo : show-ahead synchronous FIFO with flush and occupancy count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_pixel_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       valid,
    output logic [DATA_W-1:0]          head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // A pop on an empty FIFO only acts if a push lands in the same cycle,
    // in which case the arriving entry is consumed straight through.
    assign w_pop  = pop  && ((r_count != '0) || push);
    assign w_push = push && ((r_count != CNT_W'(DEPTH)) || pop);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wptr] <= push_data;
    end

    assign count = r_count;
    assign valid = (r_count != '0);
    assign head  = valid ? r_mem[r_rptr] : '0;

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter : single-port framebuffer scheduler, display prefetch vs host
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_PIX  = DEF_FRAME_PIX,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              disp_frame_start,
    input  logic              disp_pop,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_pixel,
    output logic [15:0]       disp_underflow_cnt,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fb_state_e         r_state;
    fb_state_e         w_state_nxt;
    fb_gnt_e           w_gnt;

    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] w_fetch_cur;
    logic [ADDR_W-1:0] w_fetch_nxt;

    logic              r_s1_disp;
    logic              r_s1_hrd;
    logic              r_s2_disp;
    logic              r_s2_hrd;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;
    logic [15:0]       r_underflow;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_valid;
    logic              w_push;
    logic              w_pop;
    logic [OCC_W-1:0]  w_occ;

    // Frame start behaves as an already-flushed FILL cycle so that address 0
    // is issued in the same cycle as the pulse.
    assign w_occ = disp_frame_start ? '0 :
                   OCC_W'(w_fifo_count) + OCC_W'(r_s1_disp) + OCC_W'(r_s2_disp);

    assign w_push = r_s2_disp && !disp_frame_start;
    assign w_pop  = disp_pop  && !disp_frame_start;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (disp_frame_start)
            w_state_nxt = FILL;
        else if ((r_state == FILL) && (w_occ >= OCC_W'(FIFO_DEPTH)))
            w_state_nxt = RUN;
    end

    always_comb begin
        w_gnt = GNT_NONE;
        if (disp_frame_start) begin
            w_gnt = GNT_DISP;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_occ < OCC_W'(FIFO_DEPTH))
                        w_gnt = GNT_DISP;
                end
                RUN: begin
                    if (w_occ < OCC_W'(LOW_WM))
                        w_gnt = GNT_DISP;
                    else if (host_req)
                        w_gnt = GNT_HOST;
                    else if (w_occ < OCC_W'(FIFO_DEPTH))
                        w_gnt = GNT_DISP;
                end
                default: w_gnt = GNT_NONE;
            endcase
        end
    end

    assign host_gnt = (w_gnt == GNT_HOST);

    always_comb begin
        w_fetch_cur = disp_frame_start ? '0 : r_fetch_addr;
        w_fetch_nxt = w_fetch_cur;
        if (w_gnt == GNT_DISP)
            w_fetch_nxt = (w_fetch_cur == ADDR_W'(FRAME_PIX - 1)) ? '0
                                                                  : w_fetch_cur + ADDR_W'(1);
    end

    // s1 tags the access on mem_* now, s2 the one whose read data is on mem_rdata.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_fetch_addr  <= '0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_s1_disp     <= 1'b0;
            r_s1_hrd      <= 1'b0;
            r_s2_disp     <= 1'b0;
            r_s2_hrd      <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_underflow   <= '0;
        end else begin
            r_fetch_addr <= w_fetch_nxt;
            r_mem_en     <= (w_gnt != GNT_NONE);
            r_mem_we     <= (w_gnt == GNT_HOST) && host_we;
            r_mem_addr   <= (w_gnt == GNT_HOST) ? host_addr :
                            (w_gnt == GNT_DISP) ? w_fetch_cur : '0;
            r_mem_wdata  <= ((w_gnt == GNT_HOST) && host_we) ? host_wdata : '0;
            r_s1_disp    <= (w_gnt == GNT_DISP);
            r_s1_hrd     <= (w_gnt == GNT_HOST) && !host_we;
            r_s2_disp    <= r_s1_disp && !disp_frame_start;
            r_s2_hrd     <= r_s1_hrd;
            r_host_rvalid <= r_s2_hrd;
            if (r_s2_hrd)
                r_host_rdata <= mem_rdata;
            if (w_pop && !w_fifo_valid && (r_underflow != 16'hFFFF))
                r_underflow <= r_underflow + 16'd1;
        end
    end

    fb_pixel_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (w_push),
        .push_data (mem_rdata),
        .pop       (w_pop),
        .flush     (disp_frame_start),
        .count     (w_fifo_count),
        .valid     (w_fifo_valid),
        .head      (disp_pixel)
    );

    assign disp_valid         = w_fifo_valid;
    assign disp_underflow_cnt = r_underflow;
    assign host_rvalid        = r_host_rvalid;
    assign host_rdata         = r_host_rdata;
    assign mem_en             = r_mem_en;
    assign mem_we             = r_mem_we;
    assign mem_addr           = r_mem_addr;
    assign mem_wdata          = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter : directed bench for vga_fb_arbiter (16-pixel frame)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_fb_arbiter;

    logic        clk;
    logic        arst_n;
    logic        disp_frame_start;
    logic        disp_pop;
    logic        disp_valid;
    logic [23:0] disp_pixel;
    logic [15:0] disp_underflow_cnt;
    logic        host_req;
    logic        host_we;
    logic [18:0] host_addr;
    logic [23:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [23:0] host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic        exp_rv [0:1023];
    logic [23:0] exp_rd [0:1023];
    logic [23:0] wmem   [0:511];
    logic        wset   [0:511];

    vga_fb_arbiter #(
        .ADDR_W     (19),
        .DATA_W     (24),
        .FRAME_PIX  (16),
        .FIFO_DEPTH (8),
        .LOW_WM     (4)
    ) dut (
        .clk                (clk),
        .arst_n             (arst_n),
        .disp_frame_start   (disp_frame_start),
        .disp_pop           (disp_pop),
        .disp_valid         (disp_valid),
        .disp_pixel         (disp_pixel),
        .disp_underflow_cnt (disp_underflow_cnt),
        .host_req           (host_req),
        .host_we            (host_we),
        .host_addr          (host_addr),
        .host_wdata         (host_wdata),
        .host_gnt           (host_gnt),
        .host_rvalid        (host_rvalid),
        .host_rdata         (host_rdata),
        .mem_en             (mem_en),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten words read back as their own address.
    always @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < 512; i++)
                wset[i] <= 1'b0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                wmem[mem_addr[8:0]] <= mem_wdata;
                wset[mem_addr[8:0]] <= 1'b1;
            end else begin
                mem_rdata <= wset[mem_addr[8:0]] ? wmem[mem_addr[8:0]] : {5'b0, mem_addr};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_px;
        int n_gnt;
        int since;

        arst_n = 1'b0; disp_frame_start = 1'b0; disp_pop = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            exp_rv[i] = 1'b0;
            exp_rd[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en",     32'(mem_en),             32'd0);
        chk("rst_disp_valid", 32'(disp_valid),         32'd0);
        chk("rst_underflow",  32'(disp_underflow_cnt), 32'd0);
        arst_n = 1'b1;

        // Underflow while idle and empty
        to_next(); disp_pop = 1'b1; to_mid();
        to_next(); to_mid();
        chk("ufl_one", 32'(disp_underflow_cnt), 32'd1);
        to_next(); disp_pop = 1'b0; to_mid();
        chk("ufl_two", 32'(disp_underflow_cnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            to_next(); to_mid();
            chk("idle_mem_en", 32'(mem_en), 32'd0);
        end

        // Fill: frame start in cycle 0
        to_next(); disp_frame_start = 1'b1; to_mid();
        chk("fill_c0_mem_en", 32'(mem_en), 32'd0);
        to_next(); disp_frame_start = 1'b0; to_mid();
        chk("fill_c1_mem_en", 32'(mem_en),     32'd1);
        chk("fill_c1_addr",   32'(mem_addr),   32'd0);
        chk("fill_c1_valid",  32'(disp_valid), 32'd0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 19'h005;
        for (int i = 2; i <= 8; i++) begin
            to_next(); to_mid();
            chk("fill_addr",     32'(mem_addr), 32'(i - 1));
            chk("fill_no_host",  32'(host_gnt), 32'd0);
            if (i == 3) begin
                chk("fill_valid_c3", 32'(disp_valid), 32'd1);
                chk("fill_pixel_c3", 32'(disp_pixel), 32'd0);
            end
        end
        to_next(); host_req = 1'b0; to_mid();
        chk("fill_stop", 32'(mem_en), 32'd0);

        // Host write on a full FIFO
        to_next();
        host_req = 1'b1; host_we = 1'b1; host_addr = 19'h100; host_wdata = 24'hABCDEF;
        to_mid();
        chk("hw_gnt", 32'(host_gnt), 32'd1);
        to_next(); host_req = 1'b0; host_we = 1'b0; to_mid();
        chk("hw_mem_en",  32'(mem_en),    32'd1);
        chk("hw_mem_we",  32'(mem_we),    32'd1);
        chk("hw_addr",    32'(mem_addr),  32'h100);
        chk("hw_wdata",   32'(mem_wdata), 32'hABCDEF);

        // Continuous pops across the 15 -> 0 wrap
        exp_px = 0;
        for (int k = 0; k < 24; k++) begin
            to_next(); disp_pop = disp_valid; to_mid();
            chk("wrap_valid", 32'(disp_valid), 32'd1);
            if (disp_pop) begin
                chk("wrap_pixel", 32'(disp_pixel), 32'(exp_px));
                exp_px = (exp_px + 1) % 16;
            end
        end

        // Contention: pop every other cycle, host reads held
        n_gnt = 0;
        since = 0;
        for (int k = 0; k < 40; k++) begin
            to_next();
            disp_pop  = ((k % 2) == 0) && disp_valid;
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = ((k % 2) == 1) ? 19'h100 : 19'h005;
            to_mid();
            if (host_gnt) begin
                exp_rv[cyc + 3] = 1'b1;
                exp_rd[cyc + 3] = (host_addr == 19'h100) ? 24'hABCDEF : 24'h000005;
                n_gnt++;
                since = 0;
            end else begin
                since++;
            end
            chk("starve_bound", 32'(since <= 8),  32'd1);
            chk("ct_rvalid",    32'(host_rvalid), 32'(exp_rv[cyc]));
            if (exp_rv[cyc])
                chk("ct_rdata", 32'(host_rdata), 32'(exp_rd[cyc]));
            chk("ct_disp_valid", 32'(disp_valid), 32'd1);
            if (disp_pop) begin
                chk("ct_pixel", 32'(disp_pixel), 32'(exp_px));
                exp_px = (exp_px + 1) % 16;
            end
        end
        chk("host_share", 32'(n_gnt >= 16), 32'd1);

        // Drain outstanding host reads, let the FIFO refill
        host_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            to_next(); disp_pop = 1'b0; to_mid();
            chk("drain_rvalid", 32'(host_rvalid), 32'(exp_rv[cyc]));
            if (exp_rv[cyc])
                chk("drain_rdata", 32'(host_rdata), 32'(exp_rd[cyc]));
        end
        chk("full_idle", 32'(mem_en), 32'd0);

        // Restart with two display reads in flight
        to_next(); disp_pop = 1'b1; to_mid();
        chk("rs_pix_a", 32'(disp_pixel), 32'(exp_px));
        exp_px = (exp_px + 1) % 16;
        to_next(); to_mid();
        chk("rs_pix_b", 32'(disp_pixel), 32'(exp_px));
        to_next(); disp_pop = 1'b0; to_mid();
        chk("rs_fetch_a", 32'(mem_en), 32'd1);
        to_next(); disp_frame_start = 1'b1; disp_pop = 1'b1; to_mid();
        chk("rs_fetch_b", 32'(mem_en), 32'd1);
        to_next(); disp_frame_start = 1'b0; disp_pop = 1'b0; to_mid();
        chk("rs_addr0",  32'(mem_addr),   32'd0);
        chk("rs_flush",  32'(disp_valid), 32'd0);
        to_next(); to_mid();
        chk("rs_stale",  32'(disp_valid), 32'd0);
        to_next(); to_mid();
        chk("rs_valid",  32'(disp_valid), 32'd1);
        chk("rs_pix0",   32'(disp_pixel), 32'd0);
        to_next(); disp_pop = 1'b1; to_mid();
        to_next(); disp_pop = 1'b0; to_mid();
        chk("rs_pix1",   32'(disp_pixel), 32'd1);
        chk("rs_ufl",    32'(disp_underflow_cnt), 32'd2);

        // Asynchronous reset in the middle of traffic
        host_req = 1'b1; host_we = 1'b0; host_addr = 19'h005;
        for (int k = 0; k < 3; k++) begin
            to_next(); disp_pop = ~disp_pop; to_mid();
        end
        to_next();
        arst_n = 1'b0;
        #1;
        chk("mrst_mem_en",  32'(mem_en),             32'd0);
        chk("mrst_mem_we",  32'(mem_we),             32'd0);
        chk("mrst_addr",    32'(mem_addr),           32'd0);
        chk("mrst_wdata",   32'(mem_wdata),          32'd0);
        chk("mrst_valid",   32'(disp_valid),         32'd0);
        chk("mrst_pixel",   32'(disp_pixel),         32'd0);
        chk("mrst_ufl",     32'(disp_underflow_cnt), 32'd0);
        chk("mrst_gnt",     32'(host_gnt),           32'd0);
        chk("mrst_rvalid",  32'(host_rvalid),        32'd0);
        chk("mrst_rdata",   32'(host_rdata),         32'd0);
        host_req = 1'b0; disp_pop = 1'b0;
        to_next(); to_next();
        arst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_next(); to_mid();
            chk("post_rst_idle", 32'(mem_en), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
